// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the core and encode stages.
// Default geometry is posit<16,1>.
package ppu_pkg;

    localparam int PPU_N          = 16;
    localparam int PPU_ES         = 1;
    localparam int TE_SIZE        = PPU_ES + $clog2(PPU_N) + 1;
    localparam int FRAC_SIZE      = PPU_N - PPU_ES - 3;
    localparam int FRAC_FULL_SIZE = 2 * (FRAC_SIZE + 1);
    localparam int K_SIZE         = TE_SIZE - PPU_ES;
    localparam int RLEN_SIZE      = K_SIZE;

    localparam logic [PPU_N-1:0] NAR    = {1'b1, {(PPU_N-1){1'b0}}};
    localparam logic [PPU_N-1:0] ZERO   = '0;
    localparam logic [PPU_N-1:0] MAXPOS = {1'b0, {(PPU_N-1){1'b1}}};
    localparam logic [PPU_N-1:0] MINPOS = {{(PPU_N-1){1'b0}}, 1'b1};

    localparam logic signed [K_SIZE-1:0] KMAX = K_SIZE'(PPU_N - 2);
    localparam logic signed [K_SIZE-1:0] KMIN = K_SIZE'(-(PPU_N - 2));

    typedef struct packed {
        logic                      sign;
        logic [TE_SIZE-1:0]        te;
        logic [FRAC_FULL_SIZE-1:0] frac;
        logic                      frac_lsb_cut_off;
        logic                      is_zero;
        logic                      is_nar;
    } s1_t;

    typedef struct packed {
        logic                 sat_hi;
        logic                 sat_lo;
        logic                 reg_neg;
        logic [RLEN_SIZE-1:0] reg_len;
        logic [PPU_ES-1:0]    e;
    } regime_t;

    // Split te into regime k and exponent e, clamping k to the encodable range.
    function automatic regime_t regime_decode(input logic [TE_SIZE-1:0] te);
        regime_t                   r;
        logic signed [K_SIZE-1:0]  k;
        logic [K_SIZE-1:0]         ku;
        k        = $signed(te[TE_SIZE-1:PPU_ES]);
        r.sat_hi = k > KMAX;
        r.sat_lo = k < KMIN;
        if (r.sat_hi) begin
            k = KMAX;
        end else if (r.sat_lo) begin
            k = KMIN;
        end
        ku        = k;
        r.reg_neg = k[K_SIZE-1];
        r.reg_len = r.reg_neg ? (~ku + RLEN_SIZE'(2)) : (ku + RLEN_SIZE'(2));
        r.e       = te[PPU_ES-1:0];
        return r;
    endfunction

endpackage

// File: rtl/posit_encode_round_if.sv
// Handshake bundle between the core arithmetic stage, the encoder
// and writeback.
interface posit_encode_round_if;
    import ppu_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic                      sign;
    logic [TE_SIZE-1:0]        te;
    logic [FRAC_FULL_SIZE-1:0] frac;
    logic                      frac_lsb_cut_off;
    logic                      is_zero;
    logic                      is_nar;
    logic                      out_valid;
    logic                      out_ready;
    logic [PPU_N-1:0]          posit;

    modport master (
        output in_valid, sign, te, frac, frac_lsb_cut_off,
        output is_zero, is_nar, out_ready,
        input  in_ready, out_valid, posit
    );

    modport slave (
        input  in_valid, sign, te, frac, frac_lsb_cut_off,
        input  is_zero, is_nar, out_ready,
        output in_ready, out_valid, posit
    );

endinterface

// File: rtl/posit_round_pack.sv
// Combinational posit assembly: regime/exponent/fraction packing,
// round-to-nearest-even, saturation and two's-complement sign.
module posit_round_pack
    import ppu_pkg::*;
#(
    parameter int N  = PPU_N,
    parameter int ES = PPU_ES,
    parameter int FW = FRAC_FULL_SIZE,
    parameter int RW = $clog2(N) + 1
) (
    input  logic          sign,
    input  logic [ES-1:0] e,
    input  logic [FW-1:0] frac,
    input  logic          cut,
    input  logic          is_zero,
    input  logic          is_nar,
    input  logic          sat_hi,
    input  logic          sat_lo,
    input  logic          reg_neg,
    input  logic [RW-1:0] reg_len,
    output logic [N-1:0]  posit
);

    localparam int W   = 2 * N + FW;
    localparam int PAD = W - 2 - ES - FW;

    logic signed [W-1:0] seed;
    logic signed [W-1:0] field;
    logic [RW-1:0]       shamt;
    logic [N-2:0]        kept;
    logic                guard;
    logic                sticky;
    logic                rnd;
    logic [N-1:0]        sum;
    logic [N-1:0]        mag;

    // The regime run is produced by sign-filling a "10"/"01" seed.
    always_comb begin
        shamt  = reg_len - RW'(2);
        seed   = {~reg_neg, reg_neg, e, frac, {PAD{1'b0}}};
        field  = seed >>> shamt;
        kept   = field[W-1 -: N-1];
        guard  = field[W-N];
        sticky = (|field[W-N-1:0]) | cut;
        rnd    = guard & (kept[0] | sticky);
        sum    = {1'b0, kept} + {{(N-1){1'b0}}, rnd};
        mag    = sum;
        if (sum[N-1]) begin
            mag = MAXPOS;
        end else if (sum == ZERO) begin
            mag = MINPOS;
        end
        if (sat_hi) begin
            mag = MAXPOS;
        end else if (sat_lo) begin
            mag = MINPOS;
        end
        posit = sign ? (ZERO - mag) : mag;
        if (is_nar) begin
            posit = NAR;
        end else if (is_zero) begin
            posit = ZERO;
        end
    end

endmodule

// File: rtl/posit_encode_round.sv
// Two-stage posit encode/round pipeline with valid/ready on both sides:
// S1 holds the core result, S2 holds the encoded posit.
module posit_encode_round
    import ppu_pkg::*;
#(
    parameter int N  = PPU_N,
    parameter int ES = PPU_ES
) (
    input logic                 clk,
    input logic                 rst,
    posit_encode_round_if.slave bus
);

    s1_t          s1_d;
    s1_t          s1_q;
    regime_t      rg;
    logic         s1_valid_d;
    logic         s1_valid_q;
    logic         s2_valid_d;
    logic         s2_valid_q;
    logic [N-1:0] posit_d;
    logic [N-1:0] posit_q;
    logic [N-1:0] packed_posit;
    logic         s2_free;
    logic         s1_adv;
    logic         in_ready;
    logic         in_fire;

    always_comb begin
        s2_free    = !s2_valid_q || bus.out_ready;
        s1_adv     = s1_valid_q && s2_free;
        in_ready   = !s1_valid_q || s2_free;
        in_fire    = bus.in_valid && in_ready;
        s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
        s2_valid_d = s1_adv || (s2_valid_q && !bus.out_ready);
        s1_d       = s1_q;
        posit_d    = posit_q;
        if (in_fire) begin
            s1_d.sign             = bus.sign;
            s1_d.te               = bus.te;
            s1_d.frac             = bus.frac;
            s1_d.frac_lsb_cut_off = bus.frac_lsb_cut_off;
            s1_d.is_zero          = bus.is_zero;
            s1_d.is_nar           = bus.is_nar;
        end
        if (s1_adv) begin
            posit_d = packed_posit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            posit_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            posit_q    <= posit_d;
        end
    end

    always_comb begin
        rg = regime_decode(s1_q.te);
    end

    posit_round_pack #(
        .N  (N),
        .ES (ES),
        .FW (FRAC_FULL_SIZE),
        .RW (RLEN_SIZE)
    ) u_pack (
        .sign    (s1_q.sign),
        .e       (rg.e),
        .frac    (s1_q.frac),
        .cut     (s1_q.frac_lsb_cut_off),
        .is_zero (s1_q.is_zero),
        .is_nar  (s1_q.is_nar),
        .sat_hi  (rg.sat_hi),
        .sat_lo  (rg.sat_lo),
        .reg_neg (rg.reg_neg),
        .reg_len (rg.reg_len),
        .posit   (packed_posit)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.posit     = posit_q;

    a_posit_known: assert property (
        @(posedge clk) disable iff (!rst)
        bus.out_valid |-> !$isunknown(bus.posit)
    );

    a_ready_low: assert property (
        @(posedge clk) disable iff (!rst)
        !in_ready |-> (s1_valid_q && s2_valid_q && !bus.out_ready)
    );

endmodule

// File: tb/tb_posit_encode_round.sv
// Scoreboard bench for posit_encode_round: directed and random results
// compared against a bit-string reference encoder.
`timescale 1ns/1ps
module tb_posit_encode_round;
    import ppu_pkg::*;

    localparam int N  = PPU_N;
    localparam int ES = PPU_ES;
    localparam int FW = FRAC_FULL_SIZE;
    localparam int TW = TE_SIZE;

    typedef struct {
        logic          sign;
        logic [TW-1:0] te;
        logic [FW-1:0] frac;
        logic          cut;
        logic          is_zero;
        logic          is_nar;
    } stim_t;

    typedef struct {
        logic [N-1:0] posit;
        int           acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    posit_encode_round_if bus();

    posit_encode_round #(.N(N), .ES(ES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   passed   = 0;
    int   cyc      = 0;
    int   rdy_mode = 1;
    bit   fixed_lat = 1'b0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Reference: write the posit as a bit string, then cut and round it.
    function automatic logic [N-1:0] ref_posit(input stim_t s);
        bit           bits[$];
        int           te_i, k, e, mag;
        bit           guard, sticky;
        logic [N-1:0] r;
        if (s.is_nar) return {1'b1, {(N-1){1'b0}}};
        if (s.is_zero) return '0;
        te_i = int'($signed(s.te));
        k    = te_i >>> ES;
        e    = te_i - (k << ES);
        if (k > N - 2) begin
            mag = (1 << (N - 1)) - 1;
        end else if (k < -(N - 2)) begin
            mag = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            for (int b = ES - 1; b >= 0; b--) bits.push_back(e[b]);
            for (int b = FW - 1; b >= 0; b--) bits.push_back(s.frac[b]);
            mag = 0;
            for (int i = 0; i < N - 1; i++) mag = mag * 2 + int'(bits[i]);
            guard  = bits[N-1];
            sticky = s.cut;
            for (int i = N; i < bits.size(); i++) sticky |= bits[i];
            if (guard && ((mag % 2 == 1) || sticky)) mag++;
            if (mag > (1 << (N - 1)) - 1) mag = (1 << (N - 1)) - 1;
            if (mag == 0) mag = 1;
        end
        r = mag[N-1:0];
        return s.sign ? -r : r;
    endfunction

    function automatic stim_t mk(input bit sg, input int te,
                                 input logic [FW-1:0] fr, input bit cut,
                                 input bit z, input bit n);
        stim_t s;
        s.sign = sg; s.te = TW'(te); s.frac = fr;
        s.cut = cut; s.is_zero = z; s.is_nar = n;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.sign             = s.sign;
        bus.te               = s.te;
        bus.frac             = s.frac;
        bus.frac_lsb_cut_off = s.cut;
        bus.is_zero          = s.is_zero;
        bus.is_nar           = s.is_nar;
        bus.in_valid         = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input stim_t s, input bit has_exp = 1'b0,
                        input logic [N-1:0] exp_val = '0);
        exp_t x;
        bit   ok = 1'b0;
        drive(s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                x.posit   = has_exp ? exp_val : ref_posit(s);
                x.acc_cyc = cyc + 1;
                exp_q.push_back(x);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin : monitor
        exp_t x;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got posit 0x%0h, required no output",
                             bus.posit);
                end else begin
                    x   = exp_q.pop_front();
                    lat = cyc + 1 - x.acc_cyc;
                    check("posit", bus.posit, x.posit);
                    if (fixed_lat) check("latency", lat, 2);
                    else check("latency_min", lat >= 2, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] ones;
        logic [FW-1:0] msb;
        logic [FW-1:0] grd;
        bit            stale;
        ones = '1;
        msb  = FW'(1) << (FW - 1);
        grd  = FW'(1) << (FW - 13);

        bus.in_valid = 1'b0;
        bus.sign = 1'b0; bus.te = '0; bus.frac = '0;
        bus.frac_lsb_cut_off = 1'b0; bus.is_zero = 1'b0; bus.is_nar = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_posit", bus.posit, 0);
        check("rst_in_ready", bus.in_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        fixed_lat = 1'b1;
        send(mk(0, 0, '0, 0, 0, 0), 1, 16'h4000);
        send(mk(1, 0, '0, 0, 0, 0), 1, 16'hC000);
        send(mk(0, 1, '0, 0, 0, 0), 1, 16'h5000);
        send(mk(0, 0, msb, 0, 0, 0), 1, 16'h4800);
        send(mk(0, 0, grd, 0, 0, 0), 1, 16'h4000);
        send(mk(0, 0, grd, 1, 0, 0), 1, 16'h4001);
        send(mk(0, 31, '0, 0, 0, 0), 1, 16'h7FFF);
        send(mk(0, -32, '0, 0, 0, 0), 1, 16'h0001);
        send(mk(0, 28, ones, 0, 0, 0), 1, 16'h7FFF);
        send(mk(1, 31, ones, 1, 0, 0), 1, 16'h8001);
        send(mk(1, -1, '0, 0, 0, 0), 1, 16'hD000);
        send(mk(0, 5, ones, 1, 1, 1), 1, 16'h8000);
        send(mk(1, 3, ones, 0, 1, 0), 1, 16'h0000);
        drain();
        fixed_lat = 1'b0;

        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(mk(0, 2, msb, 0, 0, 0));
        send(mk(1, -3, grd, 1, 0, 0));
        drive(mk(0, 7, ones, 0, 0, 0));
        @(negedge clk);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_posit", bus.posit, ref_posit(mk(0, 2, msb, 0, 0, 0)));
        @(negedge clk);
        check("bp_in_ready_low2", bus.in_ready, 0);
        check("bp_hold_posit2", bus.posit, ref_posit(mk(0, 2, msb, 0, 0, 0)));
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send(mk(0, 7, ones, 0, 0, 0));
        send(mk(1, -20, msb, 0, 0, 0));
        drain();

        send(mk(0, 4, '0, 0, 0, 0));
        send(mk(0, 6, '0, 0, 0, 0));
        #1 rst = 1'b0;
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        stale = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", bus.in_ready, 1);
        repeat (6) begin
            @(negedge clk);
            stale |= bus.out_valid;
        end
        check("no_stale_output", stale, 0);
        @(posedge clk);
        #1;

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            stim_t         s;
            logic [FW-1:0] m;
            s.sign    = 1'($urandom_range(0, 1));
            s.te      = TW'($urandom);
            s.frac    = FW'($urandom);
            s.cut     = 1'($urandom_range(0, 1));
            s.is_nar  = ($urandom_range(0, 15) == 0);
            s.is_zero = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                m      = '1;
                m      = m >> $urandom_range(0, FW - 1);
                s.frac = s.frac & ~m;
                s.cut  = 1'b0;
            end
            send(s);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/posit_encode_round.md
Name: posit_encode_round

Overview:
- Pipelined stage directly downstream of the core arithmetic stage in the PPU datapath.
- Consumes the core result: sign, total exponent te, fraction frac, lsb cut-off flag, and special-case flags.
- Packs the result into an N-bit posit (regime/exponent/fraction) with round-to-nearest-even, saturation and two's-complement sign.
- Uses a valid/ready handshake on both sides so the divider and later writeback stages can stall it.

Parameters:
N, 16, posit width in bits
ES, 1, exponent field width in bits

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept a result
sign  input  1  result sign
te  input  TE_SIZE  signed total exponent (k*2^ES + e)
frac  input  FRAC_FULL_SIZE  fraction bits, MSB-aligned, hidden bit removed
frac_lsb_cut_off  input  1  nonzero bits were discarded upstream (sticky)
is_zero  input  1  special result zero
is_nar  input  1  special result NaR
out_valid  output  1  posit valid
out_ready  input  1  downstream accepts
posit  output  N  encoded posit

Behaviour:
- Reset (rst=0, asynchronous): S1/S2 valid flags cleared; out_valid=0, posit=0. in_ready=1 after reset. Reset mid-operation drops all in-flight results; nothing is emitted for them.
- Transfers: in = in_valid&in_ready; out = out_valid&out_ready. Latency 2 cycles: a result accepted at edge t is presented at t+2 when no stall occurs. Throughput is 1 per cycle.
- Stall rule: S2 holds while out_valid&!out_ready. S1 advances when S2 is empty or S2 transfers. in_ready = !s1_valid | s1_advance (combinational, no bubble).
- Held outputs: posit and out_valid stay stable while stalled.
- S1 (register inputs, regime decode):
  - k = te >>> ES (arithmetic shift); e = te[ES-1:0].
  - k is clamped to [-(N-2), N-2]; sat_hi/sat_lo are set when clamping occurs.
  - Regime length: k+2 for k≥0, -k+1 for k<0.
- S2 (assembly and rounding):
  - Build a (2N+FRAC_FULL_SIZE)-bit field regime||e||frac, left-justified after the sign bit.
  - Keep the top N-1 bits. guard = next bit. sticky = OR(remaining bits) | frac_lsb_cut_off.
  - Round up iff guard & (lsb | sticky).
  - A magnitude carry into the sign position is forbidden: a result rounding beyond maxpos gives maxpos (0x7FF..F).
  - A nonzero result rounding to 0 gives minpos (0x00..01).
  - sat_hi gives maxpos; sat_lo gives minpos.
  - Sign applied last: posit = sign ? -mag : mag (two's complement, N bits).
- Special cases: is_nar gives 1<<(N-1) and has priority over is_zero. is_zero gives 0. Sign, te and frac are ignored for both.
- Simultaneous events in one cycle: input accept, S1→S2 move and output transfer all proceed together.
- Assertions: no X on posit while out_valid=1; in_ready=0 only while both stages are full and out_ready=0.

Decomposition:
- Shared package ppu_pkg holds:
  - TE_SIZE = ES + $clog2(N) + 1 and FRAC_FULL_SIZE, both shared with the core arithmetic stage;
  - constants NAR, ZERO, MAXPOS and MINPOS as functions of N;
  - a struct packing {sign, te, frac, frac_lsb_cut_off, is_zero, is_nar} for the S1 register.
- Sub-module posit_round_pack: combinational S2 datapath (assembly, RNE, saturation, sign). The handshake and pipeline registers stay in the top module.

Test Plan (N=16, ES=1):
- te=0, frac=0, sign=0 -> 0x4000. Same with sign=1 -> 0xC000. te=1 -> 0x5000. te=0 with frac MSB=1 -> 0x4800. Each appears 2 cycles after accept with out_ready held high.
- RNE: te=0, frac bit 12 from MSB (guard) =1, all else 0, cut_off=0 -> 0x4000 (tie rounds to even). Same with cut_off=1 -> 0x4001.
- Saturation: te=31 -> 0x7FFF. te=-32 -> 0x0001. te=28 with all frac bits 1 -> 0x7FFF (no wrap into the sign bit).
- Specials: is_nar=1 with is_zero=1 -> 0x8000. is_zero=1, sign=1 -> 0x0000.
- Backpressure: stream 4 results with out_ready=0 for cycles 2-5. in_ready falls after 2 accepts. posit stays stable while stalled. All 4 results emerge in order with none lost or duplicated.
- Reset: assert rst=0 while 2 results are in flight -> out_valid=0 immediately (asynchronous). After release, in_ready=1 and no stale output appears.
